l2_bank_rr_arbiter: RTL

// Round-robin arbiter sharing one single-ported L2 SRAM bank between N TCDM requesters
// (4 AXI64->TCDM32 bridge ports + 2 uDMA TCDM channels) inside the L2 subsystem.

---
 rtl/l2_bank_rr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter that shares one single-ported L2 SRAM bank between N TCDM requesters.
// Grants one access per cycle, returns a 1-cycle response to the granted port and counts conflict cycles.
module l2_bank_rr_arbiter #(
    parameter int N_PORTS    = 6,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_PORTS-1:0]                req_i,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]     add_i,
    input  logic [N_PORTS-1:0]                wen_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]     wdata_i,
    input  logic [N_PORTS*(DATA_WIDTH/8)-1:0] be_i,
    output logic [N_PORTS-1:0]                gnt_o,
    output logic [N_PORTS-1:0]                r_valid_o,
    output logic [DATA_WIDTH-1:0]             r_rdata_o,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [ADDR_WIDTH-1:0]             mem_addr_o,
    output logic [DATA_WIDTH-1:0]             mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           mem_be_o,
    input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
    input  logic                              cnt_clr_i,
    output logic [CNT_WIDTH-1:0]              conflict_cnt_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner_p0;
    logic             any_req_p0;
    logic             conflict_p0;
    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand;

    logic             resp_vld_p1;
    logic [PTR_W-1:0] resp_idx_p1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        if (val == {CNT_WIDTH{1'b1}}) begin
            return val;
        end
        return val + CNT_WIDTH'(1);
    endfunction

    function automatic logic [N_PORTS-1:0] one_hot(input logic [PTR_W-1:0] idx);
        return N_PORTS'(1) << idx;
    endfunction

    // Stage p0: combinational search starting at rr_ptr, wrapping modulo N_PORTS
    always_comb begin
        winner_p0  = '0;
        any_req_p0 = 1'b0;
        cand_sum   = '0;
        cand       = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand_sum >= (PTR_W+1)'(N_PORTS)) begin
                cand_sum = cand_sum - (PTR_W+1)'(N_PORTS);
            end
            cand = cand_sum[PTR_W-1:0];
            if (!any_req_p0 && req_i[cand]) begin
                any_req_p0 = 1'b1;
                winner_p0  = cand;
            end
        end
    end

    // Two or more requesters set means at least one is denied this cycle
    assign conflict_p0 = |(req_i & (req_i - N_PORTS'(1)));

    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = add_i[int'(winner_p0)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_o = wdata_i[int'(winner_p0)*DATA_WIDTH +: DATA_WIDTH];
        mem_be_o    = be_i[int'(winner_p0)*BE_WIDTH +: BE_WIDTH];
        if (any_req_p0 && !rst_i) begin
            gnt_o     = one_hot(winner_p0);
            mem_req_o = 1'b1;
            mem_we_o  = ~wen_i[winner_p0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            resp_vld_p1 <= 1'b0;
            resp_idx_p1 <= '0;
        end else begin
            if (any_req_p0) begin
                rr_ptr <= (winner_p0 == PTR_W'(N_PORTS-1)) ? '0 : winner_p0 + PTR_W'(1);
            end
            resp_vld_p1 <= any_req_p0;
            resp_idx_p1 <= winner_p0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            conflict_cnt_o <= '0;
        end else if (conflict_p0) begin
            conflict_cnt_o <= sat_inc(conflict_cnt_o);
        end
    end

    // Stage p1: response routed to the port granted last cycle; reset suppresses it at once
    always_comb begin
        r_valid_o = '0;
        if (resp_vld_p1 && !rst_i) begin
            r_valid_o = one_hot(resp_idx_p1);
        end
    end

    assign r_rdata_o = mem_rdata_i;

endmodule
